// File: rtl/cordic_datapath_if.sv
// Strobe/result bundle between the CORDIC controller (master) and the datapath (slave).
interface cordic_datapath_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] target_angle;
  logic                    start;
  logic                    startLoop;
  logic                    X_signal;
  logic                    Y_signal;
  logic                    angle_signal;
  logic                    t1_signal;
  logic                    t2_signal;
  logic                    verify_angleGreaterA;
  logic                    angleGreaterA;
  logic                    doneLoop;
  logic                    done;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;

  modport master (
    output target_angle, start, startLoop, X_signal, Y_signal, angle_signal,
           t1_signal, t2_signal, verify_angleGreaterA,
    input  angleGreaterA, doneLoop, done, cos_out, sin_out
  );

  modport slave (
    input  target_angle, start, startLoop, X_signal, Y_signal, angle_signal,
           t1_signal, t2_signal, verify_angleGreaterA,
    output angleGreaterA, doneLoop, done, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_datapath.sv
// Rotation-mode CORDIC datapath: each controller strobe performs one register transfer;
// no sequencing decisions are made here.
module cordic_datapath #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14,
  parameter int IW    = 4
) (
  input logic             clk,
  input logic             rst,
  cordic_datapath_if.slave bus
);

  localparam logic signed [WIDTH-1:0] K_INIT = WIDTH'(9949);

  logic signed [WIDTH-1:0] x_q, y_q, z_q, t1_q, t2_q, a_q;
  logic [IW-1:0]           i_q;
  logic                    agt_q, done_loop_q, done_q;
  logic                    active;
  logic [IW-1:0]           i_inc;
  logic signed [WIDTH-1:0] atan_i;

  function automatic logic signed [WIDTH-1:0] atan_rom(input logic [IW-1:0] idx);
    if (int'(idx) >= ITER) return '0;
    case (int'(idx))
      0:  return WIDTH'(12868);
      1:  return WIDTH'(7596);
      2:  return WIDTH'(4014);
      3:  return WIDTH'(2037);
      4:  return WIDTH'(1023);
      5:  return WIDTH'(512);
      6:  return WIDTH'(256);
      7:  return WIDTH'(128);
      8:  return WIDTH'(64);
      9:  return WIDTH'(32);
      10: return WIDTH'(16);
      11: return WIDTH'(8);
      12: return WIDTH'(4);
      13: return WIDTH'(2);
      default: return '0;
    endcase
  endfunction

  // Once i reaches ITER the rotation strobes are frozen so i can never wrap.
  assign active = (i_q != IW'(ITER));
  assign i_inc  = i_q + IW'(1);
  assign atan_i = atan_rom(i_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      a_q         <= '0;
      i_q         <= '0;
      agt_q       <= 1'b0;
      done_loop_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.start) begin
      x_q         <= K_INIT;
      y_q         <= '0;
      z_q         <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      a_q         <= bus.target_angle;
      i_q         <= '0;
      agt_q       <= 1'b0;
      done_loop_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (bus.verify_angleGreaterA) agt_q <= (z_q > a_q);
      if (active) begin
        if (bus.t1_signal) t1_q <= x_q >>> i_q;
        if (bus.t2_signal) t2_q <= y_q >>> i_q;
        if (bus.X_signal)  x_q  <= agt_q ? x_q + t2_q : x_q - t2_q;
        if (bus.Y_signal)  y_q  <= agt_q ? y_q - t1_q : y_q + t1_q;
        if (bus.angle_signal) begin
          z_q         <= agt_q ? z_q - atan_i : z_q + atan_i;
          i_q         <= i_inc;
          done_loop_q <= (i_inc == IW'(ITER));
        end
      end
      if (bus.startLoop && !active) begin
        done_loop_q <= 1'b1;
        done_q      <= 1'b1;
      end
    end
  end

  assign bus.angleGreaterA = agt_q;
  assign bus.doneLoop      = done_loop_q;
  assign bus.done          = done_q;
  assign bus.cos_out       = x_q;
  assign bus.sin_out       = y_q;

endmodule

// File: tb/tb_cordic_datapath.sv
// Self-checking bench for cordic_datapath: table vectors, random angles against an
// integer CORDIC model, and hand-written boundary/restart/reset sequences.
module tb_cordic_datapath;

  localparam int WIDTH = 16;
  localparam int ITER  = 14;

  localparam logic [7:0] S_START = 8'h80;
  localparam logic [7:0] S_LOOP  = 8'h40;
  localparam logic [7:0] S_X     = 8'h20;
  localparam logic [7:0] S_Y     = 8'h10;
  localparam logic [7:0] S_ANG   = 8'h08;
  localparam logic [7:0] S_T1    = 8'h04;
  localparam logic [7:0] S_T2    = 8'h02;
  localparam logic [7:0] S_VER   = 8'h01;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cordic_datapath_if #(.WIDTH(WIDTH)) bus ();

  cordic_datapath #(.WIDTH(WIDTH), .ITER(ITER), .IW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int angle;
    int exp_cos;
    int exp_sin;
    int exp_agt0;
    int exp_z0;
  } vec_t;

  vec_t vecs[3];
  int   atan_tab[ITER] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2};

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  // Textbook rotation-mode CORDIC in plain integers.
  task automatic model(input int a, output int c, output int s);
    int x, y, z, tx, ty;
    x = 9949; y = 0; z = 0;
    for (int k = 0; k < ITER; k++) begin
      tx = x >>> k;
      ty = y >>> k;
      if (z > a) begin
        x = wrap16(x + ty); y = wrap16(y - tx); z = wrap16(z - atan_tab[k]);
      end else begin
        x = wrap16(x - ty); y = wrap16(y + tx); z = wrap16(z + atan_tab[k]);
      end
    end
    c = x; s = y;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic drive(input logic [7:0] s);
    bus.start                = s[7];
    bus.startLoop            = s[6];
    bus.X_signal             = s[5];
    bus.Y_signal             = s[4];
    bus.angle_signal         = s[3];
    bus.t1_signal            = s[2];
    bus.t2_signal            = s[1];
    bus.verify_angleGreaterA = s[0];
  endtask

  task automatic step(input logic [7:0] s);
    @(negedge clk);
    drive(s);
    @(posedge clk);
    #1;
    drive(8'h00);
  endtask

  task automatic iterate(input int n);
    for (int k = 0; k < n; k++) begin
      step(S_VER);
      step(S_T1 | S_T2);
      step(S_X | S_Y | S_ANG);
    end
  endtask

  task automatic run_seq(input int a, output int agt0, output int z0);
    bus.target_angle = WIDTH'(a);
    step(S_START);
    agt0 = -1; z0 = 0;
    for (int k = 0; k < ITER; k++) begin
      step(S_VER);
      if (k == 0) agt0 = int'(bus.angleGreaterA);
      step(S_T1 | S_T2);
      step(S_X | S_Y | S_ANG);
      if (k == 0) z0 = int'($signed(dut.z_q));
    end
  endtask

  initial begin
    int agt0, z0, mc, ms, a, xs, ys, zs, is;
    errors = 0;
    checks = 0;
    vecs[0] = '{angle: 0,      exp_cos: 16384, exp_sin: 0,      exp_agt0: 0, exp_z0: 12868};
    vecs[1] = '{angle: 8579,   exp_cos: 14189, exp_sin: 8192,   exp_agt0: 0, exp_z0: 12868};
    vecs[2] = '{angle: -12868, exp_cos: 11585, exp_sin: -11585, exp_agt0: 1, exp_z0: -12868};

    rst = 1'b1;
    bus.target_angle = '0;
    drive(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_cos", int'(bus.cos_out), 0);
    check("reset_sin", int'(bus.sin_out), 0);
    check("reset_agt", int'(bus.angleGreaterA), 0);
    check("reset_doneloop", int'(bus.doneLoop), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      run_seq(vecs[v].angle, agt0, z0);
      check("vec_agt0", agt0, vecs[v].exp_agt0);
      check("vec_z0", z0, vecs[v].exp_z0);
      check("vec_doneloop_pre", int'(bus.doneLoop), 1);
      check("vec_done_pre", int'(bus.done), 0);
      step(S_LOOP);
      check_tol("vec_cos", int'(bus.cos_out), vecs[v].exp_cos, 8);
      check_tol("vec_sin", int'(bus.sin_out), vecs[v].exp_sin, 8);
      model(vecs[v].angle, mc, ms);
      check("vec_cos_model", int'(bus.cos_out), mc);
      check("vec_sin_model", int'(bus.sin_out), ms);
      check("vec_doneloop", int'(bus.doneLoop), 1);
      check("vec_done", int'(bus.done), 1);
    end

    for (int r = 0; r < 20; r++) begin
      a = int'($urandom_range(51472, 0)) - 25736;
      run_seq(a, agt0, z0);
      step(S_LOOP);
      model(a, mc, ms);
      check("rand_cos", int'(bus.cos_out), mc);
      check("rand_sin", int'(bus.sin_out), ms);
      check("rand_done", int'(bus.done), 1);
    end

    // Saturated loop: further rotation strobes must not move anything.
    xs = int'(bus.cos_out); ys = int'(bus.sin_out);
    zs = int'($signed(dut.z_q)); is = int'(dut.i_q);
    check("bound_i", is, ITER);
    step(S_VER);
    step(S_T1 | S_T2);
    step(S_X | S_Y | S_ANG);
    step(S_X | S_Y | S_ANG | S_T1 | S_T2);
    check("bound_x", int'(bus.cos_out), xs);
    check("bound_y", int'(bus.sin_out), ys);
    check("bound_z", int'($signed(dut.z_q)), zs);
    check("bound_i_after", int'(dut.i_q), ITER);
    check("bound_doneloop", int'(bus.doneLoop), 1);
    check("bound_done", int'(bus.done), 1);

    bus.target_angle = WIDTH'(4000);
    step(S_START);
    check("start_clears_done", int'(bus.done), 0);
    iterate(1);
    step(S_LOOP);
    check("early_loop_done", int'(bus.done), 0);
    check("early_loop_doneloop", int'(bus.doneLoop), 0);
    iterate(ITER - 2);
    check("i13_doneloop", int'(bus.doneLoop), 0);
    iterate(1);
    check("i14_doneloop", int'(bus.doneLoop), 1);

    // Restart mid-loop with competing strobes.
    bus.target_angle = WIDTH'(8579);
    step(S_START);
    iterate(5);
    check("prio_i_before", int'(dut.i_q), 5);
    step(S_START | S_X | S_ANG);
    check("prio_x", int'(bus.cos_out), 9949);
    check("prio_y", int'(bus.sin_out), 0);
    check("prio_z", int'($signed(dut.z_q)), 0);
    check("prio_i", int'(dut.i_q), 0);
    check("prio_done", int'(bus.done), 0);

    // Asynchronous reset between edges.
    iterate(7);
    check("rst_pre_sin_nonzero", int'(bus.sin_out != 0), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cos", int'(bus.cos_out), 0);
    check("arst_sin", int'(bus.sin_out), 0);
    check("arst_agt", int'(bus.angleGreaterA), 0);
    check("arst_doneloop", int'(bus.doneLoop), 0);
    check("arst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(8'h00);
    check("post_rst_cos", int'(bus.cos_out), 0);
    check("post_rst_sin", int'(bus.sin_out), 0);
    check("post_rst_done", int'(bus.done), 0);
    check("post_rst_i", int'(dut.i_q), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
